// File: rtl/hsv2rgb_arbiter_if.sv
// Requester A/B handshake and result buses plus the shared converter hookup.
// The master side is the requesters and the converter; the slave side is the arbiter.
interface hsv2rgb_arbiter_if;
  logic        a_req;
  logic [23:0] a_hsv;
  logic        a_gnt;
  logic        a_rgb_valid;
  logic [23:0] a_rgb;
  logic        b_req;
  logic [23:0] b_hsv;
  logic        b_gnt;
  logic        b_rgb_valid;
  logic [23:0] b_rgb;
  logic [23:0] cv_hsv;
  logic [23:0] cv_rgb;
  logic        busy;

  modport master (
    output a_req, a_hsv, b_req, b_hsv, cv_rgb,
    input  a_gnt, a_rgb_valid, a_rgb, b_gnt, b_rgb_valid, b_rgb, cv_hsv, busy
  );

  modport slave (
    input  a_req, a_hsv, b_req, b_hsv, cv_rgb,
    output a_gnt, a_rgb_valid, a_rgb, b_gnt, b_rgb_valid, b_rgb, cv_hsv, busy
  );
endinterface

// File: rtl/hsv2rgb_arbiter.sv
// Shares one HSV-to-RGB converter between requesters A and B.
// One grant per clock loads the converter input register. A tag pipe of
// LAT+1 stages follows each sample so that its result is routed back to
// the requester that issued it.
module hsv2rgb_arbiter #(
  parameter int LAT        = 2,
  parameter int A_PRIO     = 0,
  parameter int STARVE_MAX = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  hsv2rgb_arbiter_if.slave bus
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  // rr_last: 1 = B was granted last, so A wins the first tie after reset
  logic          rr_last_q,    rr_last_d;
  logic [7:0]    starve_cnt_q, starve_cnt_d;
  logic [23:0]   cv_hsv_q,     cv_hsv_d;
  // tag_own: 0 = sample belongs to A, 1 = sample belongs to B
  logic [LAT:0]  tag_vld_q,    tag_vld_d;
  logic [LAT:0]  tag_own_q,    tag_own_d;
  logic          a_vld_q,      a_vld_d;
  logic          b_vld_q,      b_vld_d;
  logic [23:0]   a_rgb_q,      a_rgb_d;
  logic [23:0]   b_rgb_q,      b_rgb_d;
  logic          a_gnt;
  logic          b_gnt;

  // Grant decision from the live requests and the arbitration state
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (A_PRIO == 0) begin
      if (bus.a_req && bus.b_req) begin
        a_gnt = rr_last_q;
        b_gnt = !rr_last_q;
      end else begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req;
      end
    end else begin
      if (bus.b_req && (starve_cnt_q == STARVE_LIM)) begin
        b_gnt = 1'b1;
      end else if (bus.a_req) begin
        a_gnt = 1'b1;
      end else begin
        b_gnt = bus.b_req;
      end
    end
  end

  // Arbitration state, converter input and tag pipe next values
  always_comb begin
    rr_last_d    = rr_last_q;
    starve_cnt_d = starve_cnt_q;
    cv_hsv_d     = cv_hsv_q;
    tag_vld_d    = '0;
    tag_own_d    = '0;

    if (a_gnt) begin
      rr_last_d = 1'b0;
      cv_hsv_d  = bus.a_hsv;
    end else if (b_gnt) begin
      rr_last_d = 1'b1;
      cv_hsv_d  = bus.b_hsv;
    end

    // Counts only while B is asking and losing; saturates instead of wrapping
    if (!bus.b_req || b_gnt) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q != 8'hFF) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    // The pipe never stalls: the converter cannot be held off either
    tag_vld_d[0] = a_gnt | b_gnt;
    tag_own_d[0] = b_gnt;
    for (int i = 1; i <= LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  // Result return: the last tag stage lines up with a settled cv_rgb
  always_comb begin
    a_vld_d = tag_vld_q[LAT] & ~tag_own_q[LAT];
    b_vld_d = tag_vld_q[LAT] &  tag_own_q[LAT];
    a_rgb_d = a_vld_d ? bus.cv_rgb : a_rgb_q;
    b_rgb_d = b_vld_d ? bus.cv_rgb : b_rgb_q;
  end

  // State registers; reset drops every in-flight tag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_q    <= 1'b1;
      starve_cnt_q <= 8'd0;
      cv_hsv_q     <= 24'd0;
      tag_vld_q    <= '0;
      tag_own_q    <= '0;
      a_vld_q      <= 1'b0;
      b_vld_q      <= 1'b0;
      a_rgb_q      <= 24'd0;
      b_rgb_q      <= 24'd0;
    end else begin
      rr_last_q    <= rr_last_d;
      starve_cnt_q <= starve_cnt_d;
      cv_hsv_q     <= cv_hsv_d;
      tag_vld_q    <= tag_vld_d;
      tag_own_q    <= tag_own_d;
      a_vld_q      <= a_vld_d;
      b_vld_q      <= b_vld_d;
      a_rgb_q      <= a_rgb_d;
      b_rgb_q      <= b_rgb_d;
    end
  end

  assign bus.a_gnt       = a_gnt;
  assign bus.b_gnt       = b_gnt;
  assign bus.cv_hsv      = cv_hsv_q;
  assign bus.a_rgb_valid = a_vld_q;
  assign bus.b_rgb_valid = b_vld_q;
  assign bus.a_rgb       = a_rgb_q;
  assign bus.b_rgb       = b_rgb_q;
  assign bus.busy        = bus.a_req | bus.b_req | (|tag_vld_q);

endmodule

// File: tb/tb_hsv2rgb_arbiter.sv
// Bench for hsv2rgb_arbiter: dut0 is round-robin with default parameters,
// dut1 is fixed priority with STARVE_MAX=3. Each DUT drives a two-stage
// behavioural HSV-to-RGB converter. Expected grants and results for dut0 come
// from a reference model of requests, grants and per-requester result queues.
module tb_hsv2rgb_arbiter;

  logic clk;
  logic reset_n;

  hsv2rgb_arbiter_if bus0 ();
  hsv2rgb_arbiter_if bus1 ();

  hsv2rgb_arbiter #(.LAT(2), .A_PRIO(0), .STARVE_MAX(15)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  hsv2rgb_arbiter #(.LAT(2), .A_PRIO(1), .STARVE_MAX(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer HSV-to-RGB, packing {R,G,B}; grey when saturation is zero
  function automatic logic [23:0] conv(input logic [23:0] hsv);
    int h, s, v, region, rem, p, q, t, r, g, b;
    h = int'(hsv[23:16]);
    s = int'(hsv[15:8]);
    v = int'(hsv[7:0]);
    if (s == 0) return {hsv[7:0], hsv[7:0], hsv[7:0]};
    region = h / 43;
    rem    = (h - region * 43) * 6;
    p = (v * (255 - s)) >> 8;
    q = (v * (255 - ((s * rem) >> 8))) >> 8;
    t = (v * (255 - ((s * (255 - rem)) >> 8))) >> 8;
    case (region)
      0:       begin r = v; g = t; b = p; end
      1:       begin r = q; g = v; b = p; end
      2:       begin r = p; g = v; b = t; end
      3:       begin r = p; g = q; b = v; end
      4:       begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  // Converter models: result is stable two edges after cv_hsv changes
  logic [23:0] cv0_s1, cv1_s1;
  always @(posedge clk) begin
    cv0_s1      <= conv(bus0.cv_hsv);
    bus0.cv_rgb <= cv0_s1;
    cv1_s1      <= conv(bus1.cv_hsv);
    bus1.cv_rgb <= cv1_s1;
  end

  typedef struct {
    int          due;
    logic [23:0] rgb;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  // Reference model for dut0
  exp_t        qa[$];
  exp_t        qb[$];
  logic        rr_last_m;     // 1 = B granted most recently
  logic [23:0] last_a, last_b;
  logic        eg_a, eg_b;
  // Observed/expected vector: {a_gnt,b_gnt,a_vld,b_vld,busy,a_rgb,b_rgb}
  logic [52:0] obs, expv;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    rr_last_m = 1'b1;
    last_a    = 24'd0;
    last_b    = 24'd0;
  endtask

  task automatic clear_inputs();
    bus0.a_req = 1'b0; bus0.a_hsv = 24'd0; bus0.b_req = 1'b0; bus0.b_hsv = 24'd0;
    bus1.a_req = 1'b0; bus1.a_hsv = 24'd0; bus1.b_req = 1'b0; bus1.b_hsv = 24'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  // Drive dut0 for one clock, sample at the falling edge, and compute the
  // expected outputs from the model. A grant seen at this sample is accepted
  // at the next rising edge; its result appears four samples later (LAT+1 edges).
  task automatic cycle0(input logic ar, input logic [23:0] ah,
                        input logic br, input logic [23:0] bh);
    logic ev_a, ev_b, busy_e;
    @(posedge clk); #2;
    bus0.a_req = ar; bus0.a_hsv = ah; bus0.b_req = br; bus0.b_hsv = bh;
    @(negedge clk);
    cyc++;
    obs = {bus0.a_gnt, bus0.b_gnt, bus0.a_rgb_valid, bus0.b_rgb_valid,
           bus0.busy, bus0.a_rgb, bus0.b_rgb};
    ev_a = 1'b0;
    ev_b = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      ev_a = 1'b1; last_a = qa[0].rgb; void'(qa.pop_front());
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      ev_b = 1'b1; last_b = qb[0].rgb; void'(qb.pop_front());
    end
    busy_e = ar | br | (qa.size() > 0) | (qb.size() > 0);
    // Lone requester wins; on a tie the one not granted last wins
    eg_a = ar && (!br || rr_last_m);
    eg_b = br && !eg_a;
    if (eg_a) begin
      qa.push_back('{cyc + 4, conv(ah)});
      rr_last_m = 1'b0;
      $display("txn cyc=%0d grant=A hsv=%h", cyc, ah);
    end
    if (eg_b) begin
      qb.push_back('{cyc + 4, conv(bh)});
      rr_last_m = 1'b1;
      $display("txn cyc=%0d grant=B hsv=%h", cyc, bh);
    end
    expv = {eg_a, eg_b, ev_a, ev_b, busy_e, last_a, last_b};
  endtask

  task automatic test_reset();
    logic [76:0] v0, v1;
    do_reset();
    #1;
    v0 = {bus0.cv_hsv, bus0.a_rgb, bus0.b_rgb, bus0.a_rgb_valid, bus0.b_rgb_valid,
          bus0.busy, bus0.a_gnt, bus0.b_gnt};
    v1 = {bus1.cv_hsv, bus1.a_rgb, bus1.b_rgb, bus1.a_rgb_valid, bus1.b_rgb_valid,
          bus1.busy, bus1.a_gnt, bus1.b_gnt};
    n_checks++;
    if (v0 !== 77'd0) begin
      n_fail++; $display("FAIL reset_dut0 actual=%h required=0", v0);
    end
    n_checks++;
    if (v1 !== 77'd0) begin
      n_fail++; $display("FAIL reset_dut1 actual=%h required=0", v1);
    end
    repeat (2) begin
      cycle0(1'b0, 24'd0, 1'b0, 24'd0);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d actual=%h required=%h", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_rr_alternate();
    logic [23:0] ha, hb;
    do_reset();
    ha = $urandom; hb = $urandom;
    for (int i = 0; i < 11; i++) begin
      cycle0(i < 6, ha, i < 6, hb);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL rr_alternate cyc=%0d actual=%h required=%h", cyc, obs, expv);
      end
      if (i < 6) begin
        n_checks++;
        if ({bus0.a_gnt, bus0.b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL rr_order step=%0d actual=%b%b required=%s", i,
                   bus0.a_gnt, bus0.b_gnt, (i % 2 == 0) ? "A" : "B");
        end
      end
      if (eg_a) ha = $urandom;
      if (eg_b) hb = $urandom;
    end
  endtask

  task automatic test_a_only();
    int na, nb;
    na = 0; nb = 0;
    for (int i = 0; i < 9; i++) begin
      cycle0(i < 4, 24'h00FF80, 1'b0, 24'd0);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL a_only cyc=%0d actual=%h required=%h", cyc, obs, expv);
      end
      if (bus0.a_rgb_valid === 1'b1) na++;
      if (bus0.b_rgb_valid === 1'b1) nb++;
    end
    n_checks++;
    if (na !== 4 || nb !== 0) begin
      n_fail++; $display("FAIL a_only_pulses actual=%0d/%0d required=4/0", na, nb);
    end
  endtask

  task automatic test_gap();
    int ca, cb, na, nb;
    logic busy_after;
    ca = -1; cb = -1; na = 0; nb = 0; busy_after = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle0(i == 0, 24'h2A80F0, i == 3, 24'hA040C0);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL gap cyc=%0d actual=%h required=%h", cyc, obs, expv);
      end
      if (bus0.a_rgb_valid === 1'b1) begin na++; ca = cyc; end
      if (bus0.b_rgb_valid === 1'b1) begin nb++; cb = cyc; end
      if (cb >= 0 && cyc == cb + 1) busy_after = bus0.busy;
    end
    n_checks++;
    if (na !== 1 || nb !== 1 || (cb - ca) !== 3) begin
      n_fail++; $display("FAIL gap_spacing actual=%0d/%0d/%0d required=1/1/3", na, nb, cb - ca);
    end
    n_checks++;
    if (busy_after !== 1'b0) begin
      n_fail++; $display("FAIL gap_busy actual=%b required=0", busy_after);
    end
  endtask

  task automatic test_sat_zero();
    int nb;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      cycle0(1'b0, 24'd0, i == 0, 24'h5500C8);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL sat_zero cyc=%0d actual=%h required=%h", cyc, obs, expv);
      end
      if (bus0.b_rgb_valid === 1'b1) begin
        nb++;
        n_checks++;
        if (bus0.b_rgb !== 24'hC8C8C8 || i != 4) begin
          n_fail++; $display("FAIL sat_zero_rgb step=%0d actual=%h required=c8c8c8 at step 4", i, bus0.b_rgb);
        end
      end
    end
    n_checks++;
    if (nb !== 1) begin
      n_fail++; $display("FAIL sat_zero_pulses actual=%0d required=1", nb);
    end
  endtask

  task automatic test_random();
    logic pa, pb;
    logic [23:0] ha, hb;
    pa = 1'b0; pb = 1'b0; ha = 24'd0; hb = 24'd0;
    for (int i = 0; i < 305; i++) begin
      if (i < 300) begin
        // Pending requests are held until granted, with occasional drops
        if (!pa) begin
          if ($urandom_range(2) != 0) begin pa = 1'b1; ha = $urandom; end
        end else if ($urandom_range(15) == 0) pa = 1'b0;
        if (!pb) begin
          if ($urandom_range(2) != 0) begin pb = 1'b1; hb = $urandom; end
        end else if ($urandom_range(15) == 0) pb = 1'b0;
      end else begin
        pa = 1'b0; pb = 1'b0;
      end
      cycle0(pa, ha, pb, hb);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL random cyc=%0d actual=%h required=%h", cyc, obs, expv);
      end
      if (eg_a) pa = 1'b0;
      if (eg_b) pb = 1'b0;
    end
  endtask

  task automatic test_prio_starve();
    exp_t qa1[$];
    exp_t qb1[$];
    logic [23:0] ha, hb;
    int starve_m, na, nb;
    logic ea, eb;
    ha = $urandom; hb = $urandom; starve_m = 0; na = 0; nb = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #2;
      bus1.a_req = (i < 8); bus1.a_hsv = ha;
      bus1.b_req = (i < 8); bus1.b_hsv = hb;
      @(negedge clk);
      if (bus1.a_rgb_valid === 1'b1) begin
        na++;
        n_checks++;
        if (qa1.size() == 0 || qa1[0].due != i || bus1.a_rgb !== qa1[0].rgb) begin
          n_fail++; $display("FAIL prio_a_result step=%0d actual=%h", i, bus1.a_rgb);
        end
        if (qa1.size() > 0) void'(qa1.pop_front());
      end
      if (bus1.b_rgb_valid === 1'b1) begin
        nb++;
        n_checks++;
        if (qb1.size() == 0 || qb1[0].due != i || bus1.b_rgb !== qb1[0].rgb) begin
          n_fail++; $display("FAIL prio_b_result step=%0d actual=%h", i, bus1.b_rgb);
        end
        if (qb1.size() > 0) void'(qb1.pop_front());
      end
      if (i < 8) begin
        // A wins ties until B has been refused STARVE_MAX cycles in a row
        eb = (starve_m == 3);
        ea = !eb;
        n_checks++;
        if ({bus1.a_gnt, bus1.b_gnt} !== {ea, eb}) begin
          n_fail++;
          $display("FAIL prio_grant step=%0d actual=%b%b required=%b%b", i,
                   bus1.a_gnt, bus1.b_gnt, ea, eb);
        end
        if (ea) begin
          qa1.push_back('{i + 4, conv(ha)});
          $display("txn prio step=%0d grant=A hsv=%h", i, ha);
          ha = $urandom;
          if (starve_m < 255) starve_m++;
        end else begin
          qb1.push_back('{i + 4, conv(hb)});
          $display("txn prio step=%0d grant=B hsv=%h", i, hb);
          hb = $urandom;
          starve_m = 0;
        end
      end
    end
    n_checks++;
    if (na !== 6 || nb !== 2) begin
      n_fail++; $display("FAIL prio_pulses actual=%0d/%0d required=6/2", na, nb);
    end
  endtask

  task automatic test_reset_midop();
    logic [76:0] v0;
    int nv;
    cycle0(1'b1, 24'h10F0F0, 1'b0, 24'd0);
    cycle0(1'b0, 24'd0, 1'b1, 24'hC0F0F0);
    cycle0(1'b0, 24'd0, 1'b0, 24'd0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    clear_inputs();
    #1;
    v0 = {bus0.cv_hsv, bus0.a_rgb, bus0.b_rgb, bus0.a_rgb_valid, bus0.b_rgb_valid,
          bus0.busy, bus0.a_gnt, bus0.b_gnt};
    n_checks++;
    if (v0 !== 77'd0) begin
      n_fail++; $display("FAIL midop_reset actual=%h required=0", v0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      cycle0(1'b0, 24'd0, 1'b0, 24'd0);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL midop_after cyc=%0d actual=%h required=%h", cyc, obs, expv);
      end
      if (bus0.a_rgb_valid === 1'b1 || bus0.b_rgb_valid === 1'b1) nv++;
    end
    n_checks++;
    if (nv !== 0) begin
      n_fail++; $display("FAIL midop_stale actual=%0d required=0", nv);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_rr_alternate();
    test_a_only();
    test_gap();
    test_sat_zero();
    test_random();
    test_prio_starve();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
